// File: rtl/sdram_device_model_if.sv
// Command/data bus between an SDRAM controller and the device model.
// master = controller side, slave = device side.
interface sdram_device_model_if;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;
    logic        sdram_dqml;
    logic        sdram_dqmh;
    logic        sdram_ncs;
    logic        sdram_nras;
    logic        sdram_ncas;
    logic        sdram_nwe;
    logic        sdram_cke;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output sdram_a, sdram_ba, sdram_dqml, sdram_dqmh,
        output sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
        output sdram_cke, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  sdram_a, sdram_ba, sdram_dqml, sdram_dqmh,
        input  sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
        input  sdram_cke, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_device_model.sv
// Cycle-accurate 16-bit SDRAM responder backed by a reduced word array.
// Define SDRAM_TIMING_CHECK_EN to enable TRCD/TRP/TRFC spacing checks.
module sdram_device_model #(
    parameter int MEM_AW = 16,
    parameter int TRCD   = 2,
    parameter int TRP    = 2,
    parameter int TRFC   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_device_model_if.slave  bus,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [15:0]          refresh_count
);
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_READ,
        B_WRITE
    } burst_e;

    logic [15:0] mem [2**MEM_AW];

    logic        mode_valid;
    logic        mode_ilv;
    logic        mode_cl3;
    logic        mode_single;
    logic [8:0]  mode_mask;
    logic [3:0]  bank_active;
    logic [12:0] bank_row [4];

    burst_e      state_q;
    burst_e      state_d;
    logic [1:0]  b_bank;
    logic [12:0] b_row;
    logic [8:0]  b_base;
    logic [8:0]  b_idx;
    logic [8:0]  b_mask;
    logic        b_ilv;
    logic        b_ap;

    logic        p1_v;
    logic        p1_cl3;
    logic [15:0] p1_d;
    logic        p2_v;
    logic [15:0] p2_d;

    cmd_e        cmd;
    logic        cmd_en;
    logic        is_lmr, is_ref, is_pre, is_act;
    logic        is_wr, is_rd, is_bst;
    logic        rw_ok;
    logic        lmr_cl_ok;
    logic [8:0]  lmr_mask;
    logic [2:0]  func_code;
    logic        tim_viol;

    logic        issue_valid;
    logic        issue_write;
    logic        issue_last;
    logic [1:0]  issue_bank;
    logic [12:0] issue_row;
    logic [8:0]  issue_base;
    logic [8:0]  issue_idx;
    logic [8:0]  issue_mask;
    logic        issue_ilv;
    logic        issue_ap;
    logic        ap_close;
    logic [8:0]  col_off;
    logic [8:0]  col_step;
    logic [8:0]  col;
    logic [MEM_AW-1:0] mem_idx;
    logic [15:0] rd_word;

    assign cmd    = cmd_e'({bus.sdram_nras, bus.sdram_ncas, bus.sdram_nwe});
    assign cmd_en = !bus.sdram_ncs && bus.sdram_cke;
    assign is_lmr = cmd_en && (cmd == CMD_LMR);
    assign is_ref = cmd_en && (cmd == CMD_REF);
    assign is_pre = cmd_en && (cmd == CMD_PRE);
    assign is_act = cmd_en && (cmd == CMD_ACT);
    assign is_wr  = cmd_en && (cmd == CMD_WR);
    assign is_rd  = cmd_en && (cmd == CMD_RD);
    assign is_bst = cmd_en && (cmd == CMD_BST);
    assign rw_ok  = mode_valid && bank_active[bus.sdram_ba];

    assign lmr_cl_ok = (bus.sdram_a[6:4] == 3'd2) ||
                       (bus.sdram_a[6:4] == 3'd3);

    // Burst-length code to in-block column mask (length minus one)
    always_comb begin
        lmr_mask = 9'd0;
        unique case (bus.sdram_a[2:0])
            3'd1:    lmr_mask = 9'd1;
            3'd2:    lmr_mask = 9'd3;
            3'd3:    lmr_mask = 9'd7;
            3'd7:    lmr_mask = 9'h1FF;
            default: lmr_mask = 9'd0;
        endcase
    end

    // Functional protocol error of the command on this edge
    always_comb begin
        func_code = 3'd0;
        unique case (1'b1)
            is_lmr: if (!lmr_cl_ok) func_code = 3'd5;
            is_act: if (bank_active[bus.sdram_ba]) func_code = 3'd3;
            is_rd, is_wr: begin
                if (!mode_valid)
                    func_code = 3'd1;
                else if (!bank_active[bus.sdram_ba])
                    func_code = 3'd2;
            end
            is_ref: if (|bank_active) func_code = 3'd4;
            default: func_code = 3'd0;
        endcase
    end

    // Burst FSM next state and the word issued on this edge
    always_comb begin
        state_d     = state_q;
        issue_valid = 1'b0;
        issue_write = 1'b0;
        issue_bank  = b_bank;
        issue_row   = b_row;
        issue_base  = b_base;
        issue_idx   = b_idx;
        issue_mask  = b_mask;
        issue_ilv   = b_ilv;
        issue_ap    = b_ap;
        if ((is_rd || is_wr) && rw_ok) begin
            issue_valid = 1'b1;
            issue_write = is_wr;
            issue_bank  = bus.sdram_ba;
            issue_row   = bank_row[bus.sdram_ba];
            issue_base  = bus.sdram_a[8:0];
            issue_idx   = 9'd0;
            issue_mask  = (is_wr && mode_single) ? 9'd0 : mode_mask;
            issue_ilv   = mode_ilv;
            issue_ap    = bus.sdram_a[10];
        end else if (bus.sdram_cke && state_q != B_IDLE && !is_bst) begin
            issue_valid = 1'b1;
            issue_write = (state_q == B_WRITE);
        end
        issue_last = (issue_idx == issue_mask);
        if (bus.sdram_cke) begin
            if (issue_valid && !issue_last)
                state_d = issue_write ? B_WRITE : B_READ;
            else if (issue_valid || is_bst)
                state_d = B_IDLE;
        end
    end

    assign ap_close = issue_valid && issue_last && issue_ap;

    // Wrapped column and backing-array index for the issued word
    always_comb begin
        col_off  = issue_base & issue_mask;
        col_step = issue_ilv ? (col_off ^ issue_idx)
                             : (col_off + issue_idx);
        col      = (issue_base & ~issue_mask) | (col_step & issue_mask);
        mem_idx  = MEM_AW'({issue_bank, issue_row, col});
    end

    assign rd_word = mem[mem_idx];

`ifdef SDRAM_TIMING_CHECK_EN
    logic [7:0] trcd_cnt [4];
    logic [7:0] trp_cnt [4];
    logic [7:0] trfc_cnt;

    assign tim_viol =
        (is_act && trp_cnt[bus.sdram_ba] != 8'd0) ||
        ((is_rd || is_wr) && trcd_cnt[bus.sdram_ba] != 8'd0) ||
        (cmd_en && cmd != CMD_NOP && trfc_cnt != 8'd0);

    // Per-bank and refresh spacing counters, loaded by their commands
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                trcd_cnt[i] <= 8'd0;
                trp_cnt[i]  <= 8'd0;
            end
            trfc_cnt <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (trcd_cnt[i] != 8'd0)
                    trcd_cnt[i] <= trcd_cnt[i] - 8'd1;
                if (trp_cnt[i] != 8'd0)
                    trp_cnt[i] <= trp_cnt[i] - 8'd1;
                if (is_act && bus.sdram_ba == 2'(i))
                    trcd_cnt[i] <= 8'(TRCD - 1);
                if ((is_pre && (bus.sdram_a[10] ||
                                bus.sdram_ba == 2'(i))) ||
                    (bus.sdram_cke && ap_close &&
                     issue_bank == 2'(i)))
                    trp_cnt[i] <= 8'(TRP - 1);
            end
            if (trfc_cnt != 8'd0)
                trfc_cnt <= trfc_cnt - 8'd1;
            if (is_ref)
                trfc_cnt <= 8'(TRFC - 1);
        end
    end
`else
    assign tim_viol = 1'b0;
`endif

    // Burst FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= B_IDLE;
        else
            state_q <= state_d;
    end

    // Write path into the backing array with per-byte masks
    always_ff @(posedge clk) begin
        if (!reset && bus.sdram_cke && issue_valid && issue_write) begin
            if (!bus.sdram_dqml)
                mem[mem_idx][7:0] <= bus.dq_in[7:0];
            if (!bus.sdram_dqmh)
                mem[mem_idx][15:8] <= bus.dq_in[15:8];
        end
    end

    // Mode, bank, burst, read pipeline and error bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_valid    <= 1'b0;
            mode_ilv      <= 1'b0;
            mode_cl3      <= 1'b0;
            mode_single   <= 1'b0;
            mode_mask     <= 9'd0;
            bank_active   <= 4'd0;
            for (int i = 0; i < 4; i++)
                bank_row[i] <= 13'd0;
            b_bank        <= 2'd0;
            b_row         <= 13'd0;
            b_base        <= 9'd0;
            b_idx         <= 9'd0;
            b_mask        <= 9'd0;
            b_ilv         <= 1'b0;
            b_ap          <= 1'b0;
            p1_v          <= 1'b0;
            p1_cl3        <= 1'b0;
            p1_d          <= 16'd0;
            p2_v          <= 1'b0;
            p2_d          <= 16'd0;
            bus.dq_out    <= 16'd0;
            bus.dq_oe     <= 1'b0;
            err           <= 1'b0;
            err_code      <= 3'd0;
            refresh_count <= 16'd0;
        end else if (bus.sdram_cke) begin
            p1_v   <= issue_valid && !issue_write;
            p1_d   <= rd_word;
            p1_cl3 <= mode_cl3;
            p2_v   <= p1_v && p1_cl3;
            p2_d   <= p1_d;
            if (p2_v) begin
                bus.dq_out <= p2_d;
                bus.dq_oe  <= 1'b1;
            end else if (p1_v && !p1_cl3) begin
                bus.dq_out <= p1_d;
                bus.dq_oe  <= 1'b1;
            end else begin
                bus.dq_out <= 16'd0;
                bus.dq_oe  <= 1'b0;
            end

            if (issue_valid) begin
                b_bank <= issue_bank;
                b_row  <= issue_row;
                b_base <= issue_base;
                b_idx  <= issue_idx + 9'd1;
                b_mask <= issue_mask;
                b_ilv  <= issue_ilv;
                b_ap   <= issue_ap;
            end
            if (ap_close)
                bank_active[issue_bank] <= 1'b0;

            if (is_lmr && lmr_cl_ok) begin
                mode_valid  <= 1'b1;
                mode_mask   <= lmr_mask;
                mode_ilv    <= bus.sdram_a[3];
                mode_cl3    <= (bus.sdram_a[6:4] == 3'd3);
                mode_single <= bus.sdram_a[9];
            end
            if (is_act) begin
                bank_active[bus.sdram_ba] <= 1'b1;
                bank_row[bus.sdram_ba]    <= bus.sdram_a;
            end
            if (is_pre) begin
                if (bus.sdram_a[10])
                    bank_active <= 4'd0;
                else
                    bank_active[bus.sdram_ba] <= 1'b0;
            end
            if (is_ref && !(|bank_active))
                refresh_count <= refresh_count + 16'd1;

            if (!err && (func_code != 3'd0 || tim_viol)) begin
                err      <= 1'b1;
                err_code <= (func_code != 3'd0) ? func_code : 3'd6;
            end
        end
    end
endmodule
